coin_input_conditioner: RTL and testbench

- Upstream front end of the vending machine on the Basys 3 board.
- Converts two raw, bouncing push-buttons (one-unit coin, two-unit coin) into clean single-cycle coin codes on a 2-bit bus.
- That bus drives the vending machine FSM's `in` port directly.
- Also keeps a saturating running total of units accepted, for display and debug.

---
 rtl/vending_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 92 +++++++++
 rtl/coin_input_conditioner.sv | 81 ++++++++
 tb/tb_coin_input_conditioner.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine datapath: coin codes consumed by the
// vending FSM and the debouncer state encoding.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMING    = 2'b01,
    PRESSED   = 2'b10,
    RELEASING = 2'b11
  } db_state_t;

  // Adds a coin value to the running total, clamping at COUNT_MAX.
  function automatic logic [7:0] sat_add(input logic [7:0] total, input logic [1:0] units);
    logic [8:0] sum;
    sum = {1'b0, total} + {7'b0, units};
    return sum[8] ? COUNT_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchronizer plus a four-state debouncer that issues a
// single registered press strobe once a high level has been stable long enough.
module btn_debounce
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             press_q, press_d;

  assign cnt_inc = cnt_q + CNT_ONE;
  assign press   = press_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // The counter always holds the length of the current opposite-level run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = ARMING;
          cnt_d   = CNT_ONE;
        end
      end
      ARMING: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASING;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASING: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/coin_input_conditioner.sv
// Turns two bouncing coin buttons into single-cycle coin codes for the vending FSM,
// serialising simultaneous presses (two-unit first) and keeping a saturating total.
module coin_input_conditioner
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_one,
  input  logic       btn_two,
  output logic [1:0] coin,
  output logic [7:0] coin_count
);

  logic       press_one;
  logic       press_two;
  logic       pend_one_q, pend_one_d;
  logic       pend_two_q, pend_two_d;
  logic       want_one;
  logic       want_two;
  logic [1:0] coin_q, coin_d;
  logic [7:0] count_q, count_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_one (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_one),
    .press  (press_one)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_two (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_two),
    .press  (press_two)
  );

  // A press that loses arbitration waits in its pending bit for the next cycle.
  always_comb begin
    coin_d     = COIN_NONE;
    pend_one_d = pend_one_q;
    pend_two_d = pend_two_q;
    want_two   = pend_two_q | press_two;
    want_one   = pend_one_q | press_one;
    if (want_two) begin
      coin_d     = COIN_TWO;
      pend_two_d = 1'b0;
      pend_one_d = want_one;
    end else if (want_one) begin
      coin_d     = COIN_ONE;
      pend_one_d = 1'b0;
    end
    count_d = sat_add(count_q, coin_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      coin_q     <= COIN_NONE;
      count_q    <= '0;
      pend_one_q <= 1'b0;
      pend_two_q <= 1'b0;
    end else begin
      coin_q     <= coin_d;
      count_q    <= count_d;
      pend_one_q <= pend_one_d;
      pend_two_q <= pend_two_d;
    end
  end

  assign coin       = coin_q;
  assign coin_count = count_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner with DEBOUNCE_CYCLES=4: directed scenarios with
// fixed expected timing, then randomized buttons/resets against a run-length model.
module tb_coin_input_conditioner;

  localparam int DB = 4;

  logic       clk;
  logic       rst;
  logic       btn_one;
  logic       btn_two;
  logic [1:0] coin;
  logic [7:0] coin_count;

  int checks   = 0;
  int failures = 0;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_one   (btn_one),
    .btn_two   (btn_two),
    .coin      (coin),
    .coin_count(coin_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each button is a level that flips after DB consecutive
  // opposite synchronized samples; a flip to high owes one coin, paid out on the
  // following edge, two-unit coins first.
  logic [1:0] m_sync1, m_sync2, m_lvl;
  int         m_run  [2];
  int         m_owed [2];
  logic [1:0] m_coin;
  int         m_count;

  always @(posedge clk) begin
    logic [1:0] smp;
    if (!rst) begin
      m_sync1 = 2'b00; m_sync2 = 2'b00; m_lvl = 2'b00;
      m_run   = '{0, 0}; m_owed = '{0, 0};
      m_coin  = 2'b00; m_count = 0;
    end else begin
      if (m_owed[1] > 0)      begin m_coin = 2'b10; m_owed[1]--; end
      else if (m_owed[0] > 0) begin m_coin = 2'b01; m_owed[0]--; end
      else                          m_coin = 2'b00;
      m_count = m_count + int'(m_coin);
      if (m_count > 255) m_count = 255;
      smp     = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = {btn_two, btn_one};
      for (int b = 0; b < 2; b++) begin
        if (smp[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_lvl[b] = smp[b];
            m_run[b] = 0;
            if (smp[b]) m_owed[b]++;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_one = 1'b1; btn_two = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (coin !== 2'b00 || coin_count !== 8'd0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d coin=%b count=%0d expected coin=00 count=0", i, coin, coin_count);
      end
    end
    rst = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      logic [1:0] exp;
      @(negedge clk);
      exp = (i == 7) ? 2'b10 : (i == 8) ? 2'b01 : 2'b00;
      checks++;
      if (coin !== exp) begin
        failures++;
        $display("FAIL reset_release_seq cycle=%0d coin=%b expected=%b", i, coin, exp);
      end
    end
    checks++;
    if (coin_count !== 8'd3) begin
      failures++;
      $display("FAIL reset_release_count count=%0d expected=3", coin_count);
    end
    btn_one = 1'b0; btn_two = 1'b0;
    cyc(12);
  endtask

  task automatic test_clean_press();
    int base;
    int pulses;
    base = m_count;
    btn_one = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      logic [1:0] exp;
      @(negedge clk);
      if (i == 20) btn_one = 1'b0;
      exp = (i == 7) ? 2'b01 : 2'b00;
      checks++;
      if (coin !== exp) begin
        failures++;
        $display("FAIL clean_press_pulse cycle=%0d coin=%b expected=%b", i, coin, exp);
      end
    end
    checks++;
    if (coin_count !== 8'(base + 1)) begin
      failures++;
      $display("FAIL clean_press_count count=%0d expected=%0d", coin_count, base + 1);
    end
    // A 3-sample release is bounce and must not re-arm the button.
    btn_one = 1'b1; cyc(8);
    btn_one = 1'b0; cyc(3);
    btn_one = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (coin !== 2'b00) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL short_release_repress pulses=%0d expected=0", pulses);
    end
    btn_one = 1'b0; cyc(DB);
    btn_one = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      logic [1:0] exp;
      @(negedge clk);
      exp = (i == 7) ? 2'b01 : 2'b00;
      checks++;
      if (coin !== exp) begin
        failures++;
        $display("FAIL full_release_repress cycle=%0d coin=%b expected=%b", i, coin, exp);
      end
    end
    btn_one = 1'b0;
    cyc(12);
  endtask

  task automatic test_bounce();
    int base;
    base = m_count;
    for (int r = 0; r < 5; r++) begin
      btn_two = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 2) btn_two = 1'b0;
        checks++;
        if (coin !== 2'b00) begin
          failures++;
          $display("FAIL bounce_reject round=%0d coin=%b expected=00", r, coin);
        end
      end
    end
    btn_two = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      logic [1:0] exp;
      @(negedge clk);
      if (i == 4) btn_two = 1'b0;
      exp = (i == 7) ? 2'b10 : 2'b00;
      checks++;
      if (coin !== exp) begin
        failures++;
        $display("FAIL bounce_then_stable cycle=%0d coin=%b expected=%b", i, coin, exp);
      end
    end
    checks++;
    if (coin_count !== 8'(base + 2)) begin
      failures++;
      $display("FAIL bounce_count count=%0d expected=%0d", coin_count, base + 2);
    end
  endtask

  task automatic test_simultaneous();
    int base;
    base = m_count;
    btn_one = 1'b1; btn_two = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      logic [1:0] exp;
      @(negedge clk);
      if (i == 8) begin btn_one = 1'b0; btn_two = 1'b0; end
      exp = (i == 7) ? 2'b10 : (i == 8) ? 2'b01 : 2'b00;
      checks++;
      if (coin !== exp) begin
        failures++;
        $display("FAIL simultaneous_seq cycle=%0d coin=%b expected=%b", i, coin, exp);
      end
    end
    checks++;
    if (coin_count !== 8'(base + 3)) begin
      failures++;
      $display("FAIL simultaneous_count count=%0d expected=%0d", coin_count, base + 3);
    end
    cyc(6);
  endtask

  task automatic test_mid_reset();
    btn_one = 1'b1;
    cyc(5);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (coin !== 2'b00 || coin_count !== 8'd0) begin
        failures++;
        $display("FAIL mid_reset_clear cycle=%0d coin=%b count=%0d expected coin=00 count=0", i, coin, coin_count);
      end
    end
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      logic [1:0] exp;
      @(negedge clk);
      exp = (i == 7) ? 2'b01 : 2'b00;
      checks++;
      if (coin !== exp) begin
        failures++;
        $display("FAIL mid_reset_held cycle=%0d coin=%b expected=%b", i, coin, exp);
      end
    end
    checks++;
    if (coin_count !== 8'd1) begin
      failures++;
      $display("FAIL mid_reset_count count=%0d expected=1", coin_count);
    end
    btn_one = 1'b0;
    cyc(12);
  endtask

  task automatic test_saturation();
    rst = 1'b0; cyc(2); rst = 1'b1;
    for (int p = 0; p < 127; p++) begin
      btn_two = 1'b1; cyc(5);
      btn_two = 1'b0; cyc(6);
    end
    cyc(4);
    checks++;
    if (coin_count !== 8'd254) begin
      failures++;
      $display("FAIL sat_254 count=%0d expected=254", coin_count);
    end
    btn_one = 1'b1; cyc(5);
    btn_one = 1'b0; cyc(10);
    checks++;
    if (coin_count !== 8'd255) begin
      failures++;
      $display("FAIL sat_255 count=%0d expected=255", coin_count);
    end
    btn_two = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      logic [1:0] exp;
      @(negedge clk);
      if (i == 5) btn_two = 1'b0;
      exp = (i == 7) ? 2'b10 : 2'b00;
      checks++;
      if (coin !== exp || coin_count !== 8'd255) begin
        failures++;
        $display("FAIL sat_hold cycle=%0d coin=%b count=%0d expected coin=%b count=255", i, coin, coin_count, exp);
      end
    end
  endtask

  task automatic test_random();
    int run_one, run_two, rst_left;
    run_one = 0; run_two = 0; rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (coin !== m_coin || coin_count !== 8'(m_count)) begin
        failures++;
        $display("FAIL random_vs_model cycle=%0d coin=%b count=%0d expected coin=%b count=%0d",
                 i, coin, coin_count, m_coin, m_count);
      end
      if (run_one == 0) begin btn_one = ~btn_one; run_one = $urandom_range(1, 9); end
      if (run_two == 0) begin btn_two = ~btn_two; run_two = $urandom_range(1, 9); end
      run_one--; run_two--;
      if (rst_left > 0) begin
        rst_left--;
        rst = (rst_left == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        rst_left = $urandom_range(1, 3);
      end
    end
    rst = 1'b1; btn_one = 1'b0; btn_two = 1'b0;
  endtask

  initial begin
    rst = 1'b0; btn_one = 1'b0; btn_two = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
